// File: rtl/ann_pkg.sv
// Shared types and constants for the feed-forward sequencer: state encoding,
// enable bit positions, per-stage ready masks and the enable decode.
package ann_pkg;

  localparam int EN_W  = 17;
  localparam int RDY_W = 12;
  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_IN,
    S_BIAS_L1,
    S_ACT_L1,
    S_LOAD_L2,
    S_BIAS_L2,
    S_ACT_L2,
    S_LOAD_OUT,
    S_DONE,
    S_ERR
  } state_t;

  localparam int EN_LD_L1A   = 0;
  localparam int EN_LD_L1B   = 1;
  localparam int EN_LD_L2A   = 2;
  localparam int EN_LD_L2B   = 3;
  localparam int EN_LD_L3A   = 4;
  localparam int EN_BIAS_1A1 = 5;
  localparam int EN_BIAS_1B3 = 10;
  localparam int EN_BIAS_1C1 = 11;
  localparam int EN_BIAS_1C3 = 13;
  localparam int EN_ACT_L1A  = 14;
  localparam int EN_ACT_L1B  = 15;
  localparam int EN_ACT_L3C  = 16;

  localparam logic [RDY_W-1:0] RDY_BIAS_L1 = 12'hFC0;
  localparam logic [RDY_W-1:0] RDY_ACT_L1  = 12'h006;
  localparam logic [RDY_W-1:0] RDY_BIAS_L2 = 12'h038;
  localparam logic [RDY_W-1:0] RDY_ACT_L2  = 12'h001;

  function automatic logic [EN_W-1:0] en_decode(input state_t s);
    logic [EN_W-1:0] e;
    e = '0;
    case (s)
      S_LOAD_IN: begin
        e[EN_LD_L1A] = 1'b1;
        e[EN_LD_L1B] = 1'b1;
      end
      S_BIAS_L1:  e[EN_BIAS_1B3:EN_BIAS_1A1] = '1;
      S_ACT_L1: begin
        e[EN_ACT_L1A] = 1'b1;
        e[EN_ACT_L1B] = 1'b1;
      end
      S_LOAD_L2: begin
        e[EN_LD_L2A] = 1'b1;
        e[EN_LD_L2B] = 1'b1;
      end
      S_BIAS_L2:  e[EN_BIAS_1C3:EN_BIAS_1C1] = '1;
      S_ACT_L2:   e[EN_ACT_L3C] = 1'b1;
      S_LOAD_OUT: e[EN_LD_L3A] = 1'b1;
      default:    e = '0;
    endcase
    return e;
  endfunction

  function automatic logic is_wait(input state_t s);
    return (s == S_BIAS_L1) || (s == S_ACT_L1) || (s == S_BIAS_L2) || (s == S_ACT_L2);
  endfunction

endpackage

// File: rtl/ann_wait_timer.sv
// Saturating 8-bit wait counter; expired_o flags the last permitted wait cycle
// so the sequencer leaves for ERR after exactly TIMEOUT_CYCLES unsatisfied cycles.
module ann_wait_timer
  import ann_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/ann_ff_sequencer.sv
// Feed-forward pass sequencer: walks load/bias/activation stages, waiting on
// stage ready masks with a timeout; enables and status are registered from next state.
module ann_ff_sequencer
  import ann_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RDY_W-1:0] ready,
  output logic [EN_W-1:0]  en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t          state_q, state_d;
  logic [EN_W-1:0] en_q;
  logic            busy_q, done_q, err_q;
  logic            tmr_clr, tmr_inc, tmr_exp;

  function automatic logic mask_ok(input logic [RDY_W-1:0] r, input logic [RDY_W-1:0] m);
    return (r & m) == m;
  endfunction

  // Ready beats timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR: if (start) state_d = S_LOAD_IN;
      S_LOAD_IN:  state_d = S_BIAS_L1;
      S_BIAS_L1: begin
        if (mask_ok(ready, RDY_BIAS_L1)) state_d = S_ACT_L1;
        else if (tmr_exp)                state_d = S_ERR;
      end
      S_ACT_L1: begin
        if (mask_ok(ready, RDY_ACT_L1)) state_d = S_LOAD_L2;
        else if (tmr_exp)               state_d = S_ERR;
      end
      S_LOAD_L2:  state_d = S_BIAS_L2;
      S_BIAS_L2: begin
        if (mask_ok(ready, RDY_BIAS_L2)) state_d = S_ACT_L2;
        else if (tmr_exp)                state_d = S_ERR;
      end
      S_ACT_L2: begin
        if (mask_ok(ready, RDY_ACT_L2)) state_d = S_LOAD_OUT;
        else if (tmr_exp)               state_d = S_ERR;
      end
      S_LOAD_OUT: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign tmr_clr = (state_d != state_q);
  assign tmr_inc = is_wait(state_q);

  ann_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .expired_o(tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_decode(state_d);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_ERR);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ann_ff_sequencer.sv
// Bench for ann_ff_sequencer: two instances (timeouts 16 and 4) share stimulus
// and are compared every cycle against a phase-table reference model.
module tb_ann_ff_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] ready;
  logic [16:0] en_w   [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        err_w  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ann_ff_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .en(en_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  ann_ff_sequencer #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .en(en_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  // Phases: 0 idle, 1 load in, 2 bias l1, 3 act l1, 4 load l2,
  // 5 bias l2, 6 act l2, 7 load out, 8 done, 9 error.
  logic [16:0] ph_en   [10];
  logic [11:0] ph_mask [10];
  int          ph      [2];
  int          waited  [2];
  int          tmo     [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i]     = 0;
      waited[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      case (ph[i])
        0, 9: if (start) ph[i] = 1;
        8:    ph[i] = 0;
        1, 4, 7: ph[i] = ph[i] + 1;
        default: begin
          waited[i]++;
          if ((ready & ph_mask[ph[i]]) == ph_mask[ph[i]]) begin
            ph[i]     = ph[i] + 1;
            waited[i] = 0;
          end else if (waited[i] >= tmo[i]) begin
            ph[i]     = 9;
            waited[i] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("en%0d", i),   32'(en_w[i]),   32'(ph_en[ph[i]]));
      chk($sformatf("busy%0d", i), 32'(busy_w[i]), (ph[i] != 0 && ph[i] != 9) ? 32'd1 : 32'd0);
      chk($sformatf("done%0d", i), 32'(done_w[i]), (ph[i] == 8) ? 32'd1 : 32'd0);
      chk($sformatf("err%0d", i),  32'(err_w[i]),  (ph[i] == 9) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_en%0d", tag, i),   32'(en_w[i]),   32'd0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("%s_done%0d", tag, i), 32'(done_w[i]), 32'd0);
      chk($sformatf("%s_err%0d", tag, i),  32'(err_w[i]),  32'd0);
    end
  endtask

  // One clock: compare at the falling edge, apply inputs, step model at the rising edge.
  task automatic cyc(input logic s, input logic [11:0] r);
    @(negedge clk);
    compare_all();
    start = s;
    ready = r;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    ph_en[0] = 17'h00000; ph_en[1] = 17'h00003; ph_en[2] = 17'h007E0;
    ph_en[3] = 17'h0C000; ph_en[4] = 17'h0000C; ph_en[5] = 17'h03800;
    ph_en[6] = 17'h10000; ph_en[7] = 17'h00010; ph_en[8] = 17'h00000;
    ph_en[9] = 17'h00000;
    for (int k = 0; k < 10; k++) ph_mask[k] = 12'h000;
    ph_mask[2] = 12'hFC0; ph_mask[3] = 12'h006;
    ph_mask[5] = 12'h038; ph_mask[6] = 12'h001;
    tmo[0] = 16;
    tmo[1] = 4;
    model_reset();

    rst   = 1'b1;
    start = 1'b0;
    ready = 12'h000;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full pass with everything ready.
    cyc(1'b1, 12'hFFF);
    for (int k = 0; k < 10; k++) cyc(1'b0, 12'hFFF);

    // Stall in BIAS_L1 until cycle 5, then stall in ACT_L1 to timeout.
    cyc(1'b1, 12'h000);
    for (int k = 1; k < 5; k++) cyc(1'b0, 12'h000);
    cyc(1'b0, 12'hFC0);
    for (int k = 0; k < 22; k++) cyc(1'b0, 12'h000);

    // Recovery from ERR into a full pass.
    cyc(1'b1, 12'hFFF);
    for (int k = 0; k < 10; k++) cyc(1'b0, 12'hFFF);

    // ready[0] arrives on the 4th ACT_L2 cycle.
    cyc(1'b1, 12'hFFE);
    for (int k = 1; k < 9; k++) cyc(1'b0, 12'hFFE);
    for (int k = 0; k < 4; k++) cyc(1'b0, 12'hFFF);

    // ready[0] arrives on the 16th ACT_L2 cycle.
    cyc(1'b1, 12'hFFE);
    for (int k = 1; k < 21; k++) cyc(1'b0, 12'hFFE);
    for (int k = 0; k < 4; k++) cyc(1'b0, 12'hFFF);

    // Bias unit 1a1 never ready.
    cyc(1'b1, 12'h7FF);
    for (int k = 0; k < 20; k++) cyc(1'b0, 12'h7FF);

    // Asynchronous reset while parked in BIAS_L2.
    cyc(1'b1, 12'hFC7);
    for (int k = 1; k < 6; k++) cyc(1'b0, 12'hFC7);
    start = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) cyc(1'b0, 12'hFFF);
    cyc(1'b1, 12'hFFF);
    for (int k = 0; k < 10; k++) cyc(1'b0, 12'hFFF);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic        s;
      logic [11:0] r;
      s = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       r = 12'($urandom);
        1:       r = 12'hFFF & ~(12'h001 << $urandom_range(0, 11));
        default: r = 12'hFFF;
      endcase
      cyc(s, r);
    end
    cyc(1'b0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
